// File: rtl/alu_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// alu_dispatch_pkg -- shared ALU definitions.
//   `ALU_DATA_WIDTH / `ALU_OPCODE_WIDTH : default operand and opcode widths
//   SYS_*                               : opcode encodings of the shared ALU
//   state_e                             : dispatcher FSM states
// ---------------------------------------------------------------------------
`ifndef ALU_SHARED_DEFS
`define ALU_SHARED_DEFS
`define ALU_DATA_WIDTH   16
`define ALU_OPCODE_WIDTH 4
`endif

package alu_dispatch_pkg;

  localparam int unsigned SYS_ADD     = 0;
  localparam int unsigned SYS_SUB     = 1;
  localparam int unsigned SYS_AND     = 2;
  localparam int unsigned SYS_OR      = 3;
  localparam int unsigned SYS_NOT     = 4;
  localparam int unsigned SYS_LESS    = 5;
  localparam int unsigned SYS_GREATER = 6;
  localparam int unsigned SYS_EQUAL   = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_RESP    = 2'd2
  } state_e;

endpackage

// File: rtl/alu_dispatch.sv
// ---------------------------------------------------------------------------
// alu_dispatch -- sequences a multi-operand command through an external
// combinational ALU as a left fold and returns one result per command.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (accepted only in IDLE)
//   cmd_opcode, cmd_argc            operation and number of operands
//   opd_valid/opd_ready, opd_data   serial operand stream
//   alu_in_0, alu_in_1, alu_opcode  drive the external combinational ALU
//   alu_result                      ALU result, same cycle
//   res_valid/res_ready             result handshake
//   res_data, res_err               result value, illegal-command flag
//   busy                            high whenever not IDLE
// ---------------------------------------------------------------------------
module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int DATA_WIDTH   = `ALU_DATA_WIDTH,
  parameter int OPCODE_WIDTH = `ALU_OPCODE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OPCODE_WIDTH-1:0] cmd_opcode,
  input  logic [3:0]              cmd_argc,
  input  logic                    opd_valid,
  output logic                    opd_ready,
  input  logic [DATA_WIDTH-1:0]   opd_data,
  output logic [DATA_WIDTH-1:0]   alu_in_0,
  output logic [DATA_WIDTH-1:0]   alu_in_1,
  output logic [OPCODE_WIDTH-1:0] alu_opcode,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_WIDTH-1:0]   res_data,
  output logic                    res_err,
  output logic                    busy
);

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD     = OPCODE_WIDTH'(SYS_ADD);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB     = OPCODE_WIDTH'(SYS_SUB);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND     = OPCODE_WIDTH'(SYS_AND);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR      = OPCODE_WIDTH'(SYS_OR);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOT     = OPCODE_WIDTH'(SYS_NOT);
  localparam logic [OPCODE_WIDTH-1:0] OP_LESS    = OPCODE_WIDTH'(SYS_LESS);
  localparam logic [OPCODE_WIDTH-1:0] OP_GREATER = OPCODE_WIDTH'(SYS_GREATER);
  localparam logic [OPCODE_WIDTH-1:0] OP_EQUAL   = OPCODE_WIDTH'(SYS_EQUAL);

  // Folding ops take any non-zero count, NOT is unary, comparisons binary.
  // Unknown opcodes and argc=0 are always rejected.
  function automatic logic arity_ok(input logic [OPCODE_WIDTH-1:0] op,
                                    input logic [3:0]              argc);
    logic ok;
    ok = 1'b0;
    if (argc != 4'd0) begin
      if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_OR)
        ok = 1'b1;
      else if (op == OP_NOT)
        ok = (argc == 4'd1);
      else if (op == OP_LESS || op == OP_GREATER || op == OP_EQUAL)
        ok = (argc == 4'd2);
    end
    return ok;
  endfunction

  state_e                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] opcode_q;
  logic [3:0]              remaining_q;
  logic [DATA_WIDTH-1:0]   acc_q;
  logic                    err_q;
  logic                    first_q;   // next accepted operand starts the fold

  logic cmd_fire, opd_fire, cmd_legal;

  assign cmd_fire  = cmd_valid && (state_q == ST_IDLE);
  assign opd_fire  = opd_valid && (state_q == ST_COLLECT);
  assign cmd_legal = arity_ok(cmd_opcode, cmd_argc);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  // NOTE: state_d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (cmd_fire) state_d = cmd_legal ? ST_COLLECT : ST_RESP;
      ST_COLLECT: if (opd_fire && remaining_q == 4'd1) state_d = ST_RESP;
      ST_RESP:    if (res_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready  = (state_q == ST_IDLE);
    opd_ready  = (state_q == ST_COLLECT);
    res_valid  = (state_q == ST_RESP);
    busy       = (state_q != ST_IDLE);
    // NOT is unary: its single operand goes straight to the ALU rather than
    // through the accumulator.
    alu_in_0   = (first_q && opcode_q == OP_NOT) ? opd_data : acc_q;
    alu_in_1   = opd_data;
    alu_opcode = opcode_q;
    res_data   = acc_q;
    res_err    = err_q;
  end

  // Datapath: command latch, operand countdown and accumulator fold.
  // acc_q doubles as the result register, so the error path clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q    <= '0;
      remaining_q <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      first_q     <= 1'b0;
    end else if (cmd_fire) begin
      opcode_q <= cmd_opcode;
      err_q    <= !cmd_legal;
      first_q  <= cmd_legal;
      if (cmd_legal) begin
        remaining_q <= cmd_argc;
      end else begin
        remaining_q <= '0;
        acc_q       <= '0;
      end
    end else if (opd_fire) begin
      remaining_q <= remaining_q - 4'd1;
      first_q     <= 1'b0;
      acc_q       <= (first_q && opcode_q != OP_NOT) ? opd_data : alu_result;
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// ---------------------------------------------------------------------------
// tb_alu_dispatch -- directed vectors for alu_dispatch with a queue-based
// scoreboard. A behavioural ALU closes the loop on the alu_* ports; the
// monitor pops one expected response per res_valid&res_ready handshake.
// ---------------------------------------------------------------------------
module tb_alu_dispatch;

  localparam int DW = 16;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [OW-1:0] cmd_opcode = '0;
  logic [3:0]    cmd_argc = '0;
  logic          opd_valid = 1'b0;
  logic          opd_ready;
  logic [DW-1:0] opd_data = '0;
  logic [DW-1:0] alu_in_0, alu_in_1, alu_result;
  logic [OW-1:0] alu_opcode;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [DW-1:0] res_data;
  logic          res_err;
  logic          busy;

  alu_dispatch #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_argc(cmd_argc),
    .opd_valid(opd_valid), .opd_ready(opd_ready), .opd_data(opd_data),
    .alu_in_0(alu_in_0), .alu_in_1(alu_in_1), .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model of the external combinational ALU
  always_comb begin
    case (alu_opcode)
      4'd0:    alu_result = alu_in_0 + alu_in_1;
      4'd1:    alu_result = alu_in_0 - alu_in_1;
      4'd2:    alu_result = alu_in_0 & alu_in_1;
      4'd3:    alu_result = alu_in_0 | alu_in_1;
      4'd4:    alu_result = ~alu_in_0;
      4'd5:    alu_result = (alu_in_0 <  alu_in_1) ? 16'd1 : 16'd0;
      4'd6:    alu_result = (alu_in_0 >  alu_in_1) ? 16'd1 : 16'd0;
      4'd7:    alu_result = (alu_in_0 == alu_in_1) ? 16'd1 : 16'd0;
      default: alu_result = '0;
    endcase
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } resp_t;

  resp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_pushed = 0;
  int n_popped = 0;
  int cyc      = 0;
  int opd_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops and result-stability checks
  logic          prev_valid = 1'b0, prev_ready = 1'b0, prev_err = 1'b0;
  logic [DW-1:0] prev_data = '0;
  resp_t         got_exp;

  always @(negedge clk) begin
    if (rst_n) begin
      if (opd_ready) opd_seen++;
      if (res_valid && prev_valid && !prev_ready) begin
        check("res_data_stable", 32'(res_data), 32'(prev_data));
        check("res_err_stable", 32'(res_err), 32'(prev_err));
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_response: got 0x%0h, expected none", res_data);
        end else begin
          got_exp = exp_q.pop_front();
          n_popped++;
          check("res_data", 32'(res_data), 32'(got_exp.data));
          check("res_err", 32'(res_err), 32'(got_exp.err));
        end
      end
    end
    prev_valid = res_valid && rst_n;
    prev_ready = res_ready;
    prev_data  = res_data;
    prev_err   = res_err;
  end

  // Issue one command with up to three operands; gap idle cycles between
  // operands, hold cycles of res_ready low, exp_lat <= 0 skips latency check.
  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [3:0] argc, input logic [15:0] d0,
                        input logic [15:0] d1, input logic [15:0] d2,
                        input int nops, input int gap, input int hold,
                        input logic [15:0] exp_d, input logic exp_e,
                        input int exp_lat);
    logic [15:0] ops [3];
    int t0;
    int seen0;
    ops = '{d0, d1, d2};
    exp_q.push_back('{exp_d, exp_e});
    n_pushed++;
    seen0 = opd_seen;
    if (hold > 0) res_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_argc = argc;
    for (int k = 0; k < 20 && !cmd_ready; k++) @(negedge clk);
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL %s_cmd_timeout: got cmd_ready=0, expected 1", name);
      cmd_valid = 1'b0;
      return;
    end
    t0 = cyc;
    @(posedge clk); #1 cmd_valid = 1'b0;
    for (int i = 0; i < nops; i++) begin
      @(negedge clk);
      opd_valid = 1'b1; opd_data = ops[i];
      for (int k = 0; k < 20 && !opd_ready; k++) @(negedge clk);
      if (!opd_ready) begin
        n_checks++; n_fail++;
        $display("FAIL %s_opd_timeout: got opd_ready=0, expected 1", name);
      end
      @(posedge clk); #1 opd_valid = 1'b0;
      repeat (gap) @(posedge clk);
    end
    @(negedge clk);
    for (int k = 0; k < 50 && !res_valid; k++) @(negedge clk);
    if (!res_valid) begin
      n_checks++; n_fail++;
      $display("FAIL %s_res_timeout: got res_valid=0, expected 1", name);
      res_ready = 1'b1;
      return;
    end
    if (exp_lat > 0) check({name, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
    if (nops == 0) check({name, "_no_opd_ready"}, 32'(opd_seen), 32'(seen0));
    if (hold > 0) begin
      // A command offered during RESP must not be taken.
      cmd_valid = 1'b1; cmd_opcode = 4'd0; cmd_argc = 4'd1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check({name, "_cmd_ready_in_resp"}, 32'(cmd_ready), 32'd0);
        check({name, "_res_valid_held"}, 32'(res_valid), 32'd1);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      res_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Values while reset is asserted
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_opd_ready", 32'(opd_ready), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_err", 32'(res_err), 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);

    //     name       op    argc   d0       d1       d2    n gap hold exp_d    e   lat
    run_op("add3",    4'd0, 4'd3, 16'd5,   16'd7,   16'd9, 3, 0, 0, 16'd21,   0,  4);
    run_op("sub2",    4'd1, 4'd2, 16'd3,   16'd5,   16'd0, 2, 0, 0, 16'hFFFE, 0,  3);
    run_op("less2",   4'd5, 4'd2, 16'd3,   16'd5,   16'd0, 2, 0, 0, 16'd1,    0,  3);
    run_op("not1",    4'd4, 4'd1, 16'h00F0,16'd0,   16'd0, 1, 0, 0, 16'hFF0F, 0,  2);
    run_op("not2",    4'd4, 4'd2, 16'd0,   16'd0,   16'd0, 0, 0, 0, 16'd0,    1,  1);
    run_op("op9",     4'd9, 4'd2, 16'd0,   16'd0,   16'd0, 0, 0, 0, 16'd0,    1,  1);
    run_op("equal0",  4'd7, 4'd0, 16'd0,   16'd0,   16'd0, 0, 0, 0, 16'd0,    1,  1);
    run_op("or_gap",  4'd3, 4'd2, 16'h0101,16'h1010,16'd0, 2, 3, 4, 16'h1111, 0, -1);
    run_op("and2",    4'd2, 4'd2, 16'hFF0F,16'h0FF0,16'd0, 2, 0, 0, 16'h0F00, 0,  3);
    run_op("gt2",     4'd6, 4'd2, 16'd9,   16'd4,   16'd0, 2, 0, 0, 16'd1,    0,  3);
    run_op("eq2",     4'd7, 4'd2, 16'd7,   16'd7,   16'd0, 2, 0, 0, 16'd1,    0,  3);
    run_op("eq2_ne",  4'd7, 4'd2, 16'd7,   16'd6,   16'd0, 2, 0, 0, 16'd0,    0,  3);
    run_op("add_wrap",4'd0, 4'd2, 16'hFFFF,16'd2,   16'd0, 2, 0, 0, 16'd1,    0,  3);
    run_op("less_ne", 4'd5, 4'd2, 16'd5,   16'd3,   16'd0, 2, 0, 0, 16'd0,    0,  3);

    // Reset in the middle of a three-operand ADD: no result may appear.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = 4'd0; cmd_argc = 4'd3;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    opd_valid = 1'b1; opd_data = 16'd5;
    @(posedge clk); #1 opd_valid = 1'b0;
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_opd_ready", 32'(opd_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_res_valid", 32'(res_valid), 32'd0);
    end
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_res_data", 32'(res_data), 32'd0);
    run_op("add1_after_rst", 4'd0, 4'd1, 16'd4, 16'd0, 16'd0, 1, 0, 0, 16'd4, 0, 2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("handshake_count", 32'(n_popped), 32'(n_pushed));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
